// File: rtl/core_dmem.sv
// Data-memory responder for the MEM stage: one RV64 load/store in flight at a time,
// served from a byte-lane doubleword array with valid/ready handshakes on request and response.
module core_dmem #(
    parameter int unsigned DEPTH_DW  = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o
);
    localparam int unsigned IDX_W = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rd_word_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [63:0] resp_rdata_q;

    logic [63:0] mem [DEPTH_DW];

    logic             accept_d;
    logic [IDX_W-1:0] rd_idx_d;
    logic [63:0]      off_d;
    logic [63:0]      idx_full_d;
    logic [IDX_W-1:0] wr_idx_d;
    logic             illegal_d;
    logic             misalign_d;
    logic             oob_d;
    logic             err_d;
    logic [3:0]       nbytes_d;
    logic [7:0]       be_d;
    logic [63:0]      wdata_sh_d;
    logic [63:0]      wr_word_d;
    logic [63:0]      rd_sh_d;
    logic [63:0]      load_d;

    // rst_n is the active-high reset; ready drops immediately while it is asserted
    assign req_ready_o = (state_q == IDLE) && !rst_n;
    assign accept_d    = req_valid_i && req_ready_o;
    assign rd_idx_d    = IDX_W'((req_addr_i - BASE_ADDR) >> 3);

    assign off_d      = addr_q - BASE_ADDR;
    assign idx_full_d = off_d >> 3;
    assign wr_idx_d   = idx_full_d[IDX_W-1:0];

    assign illegal_d = (funct3_q == 3'b111) || (we_q && funct3_q[2]);
    always_comb begin
        misalign_d = 1'b0;
        case (funct3_q[1:0])
            2'b01:   misalign_d = addr_q[0];
            2'b10:   misalign_d = |addr_q[1:0];
            2'b11:   misalign_d = |addr_q[2:0];
            default: misalign_d = 1'b0;
        endcase
    end
    assign oob_d = (addr_q < BASE_ADDR) || (idx_full_d >= 64'(DEPTH_DW));
    assign err_d = illegal_d || misalign_d || oob_d;

    // Store merge: the word read at accept time is patched lane by lane, then written back whole
    assign nbytes_d   = 4'd1 << funct3_q[1:0];
    assign wdata_sh_d = wdata_q << {addr_q[2:0], 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign be_d[gi] = ({1'b0, addr_q[2:0]} <= 4'(gi)) &&
                              (4'(gi) < ({1'b0, addr_q[2:0]} + nbytes_d));
            assign wr_word_d[gi*8 +: 8] = be_d[gi] ? wdata_sh_d[gi*8 +: 8] : rd_word_q[gi*8 +: 8];
        end
    endgenerate

    assign rd_sh_d = rd_word_q >> {addr_q[2:0], 3'b000};
    always_comb begin
        load_d = '0;
        case (funct3_q)
            3'b000:  load_d = {{56{rd_sh_d[7]}},  rd_sh_d[7:0]};
            3'b001:  load_d = {{48{rd_sh_d[15]}}, rd_sh_d[15:0]};
            3'b010:  load_d = {{32{rd_sh_d[31]}}, rd_sh_d[31:0]};
            3'b011:  load_d = rd_sh_d;
            3'b100:  load_d = {56'd0, rd_sh_d[7:0]};
            3'b101:  load_d = {48'd0, rd_sh_d[15:0]};
            3'b110:  load_d = {32'd0, rd_sh_d[31:0]};
            default: load_d = '0;
        endcase
    end

    // Array port: registered read at accept, write at the BUSY->RESP edge unless reset is asserted
    always_ff @(posedge clk) begin
        if (accept_d) begin
            rd_word_q <= mem[rd_idx_d];
        end
        if (!rst_n && (state_q == BUSY) && we_q && !err_d) begin
            mem[wr_idx_d] <= wr_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q     <= req_we_i;
                        funct3_q <= req_funct3_i;
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_d;
                    resp_rdata_q <= (we_q || err_d) ? 64'd0 : load_d;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
endmodule

// File: tb/tb_core_dmem.sv
// Directed and randomized checks of core_dmem against a byte-addressed reference memory.
module tb_core_dmem;
    localparam int unsigned DEPTH     = 1024;
    localparam logic [63:0] BASE      = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [63:0] req_addr_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] mm [0:8*DEPTH-1];

    core_dmem #(.DEPTH_DW(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-granular memory, size = 2**funct3[1:0] bytes
    task automatic model(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, output logic [63:0] rd, output bit er);
        int nb;
        longint unsigned a;
        nb = 1 << f3[1:0];
        rd = '0;
        er = (f3 == 3'd7) || (we && f3 >= 3'd4) || ((addr % nb) != 0) ||
             (addr < BASE) || (((addr - BASE) / 8) >= DEPTH);
        if (!er) begin
            a = addr - BASE;
            if (we) begin
                for (int k = 0; k < nb; k++) mm[int'(a) + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < nb; k++) rd[8*k +: 8] = mm[int'(a) + k];
                if (f3 < 3'd3 && rd[8*nb-1]) rd = rd | (~64'd0 << (8*nb));
            end
        end
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd);
        int cnt;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wd;
        cnt = 0;
        while (!req_ready_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) chk("accept_timeout", 64'(cnt), 64'd0);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic collect(output logic [63:0] rd, output logic er);
        @(negedge clk);
        chk("lat_busy_valid", 64'(resp_valid_o), 64'd0);
        @(negedge clk);
        chk("lat_resp_valid", 64'(resp_valid_o), 64'd1);
        rd = resp_rdata_o;
        er = resp_err_o;
        @(posedge clk);
    endtask

    task automatic xact(input string tag, input bit we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er);
        logic [63:0] exp_rd;
        bit exp_er;
        model(we, f3, addr, wd, exp_rd, exp_er);
        issue(we, f3, addr, wd);
        collect(rd, er);
        $display("xact %s we=%0d f3=%0d addr=%h wd=%h -> rdata=%h err=%0d", tag, we, f3, addr, wd, rd, er);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 64'(er), 64'(exp_er));
    endtask

    initial begin
        logic [63:0] rd, rd0;
        logic er;
        logic [63:0] a, d;
        bit we;
        logic [2:0] f3;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_rdata", resp_rdata_o, 64'd0);
        chk("rst_err", 64'(resp_err_o), 64'd0);
        rst_n = 1'b0;
        #1 chk("post_rst_ready", 64'(req_ready_o), 64'd1);

        // Basic store / load and field extraction
        xact("sd_10", 1, 3'b011, 64'h10, 64'h8877665544332211, rd, er);
        chk("sd_10_lit_rd", rd, 64'd0);
        chk("sd_10_lit_err", 64'(er), 64'd0);
        xact("ld_10", 0, 3'b011, 64'h10, 64'h0, rd, er);
        chk("ld_10_lit", rd, 64'h8877665544332211);
        xact("lb_17", 0, 3'b000, 64'h17, 64'h0, rd, er);
        chk("lb_17_lit", rd, 64'hFFFFFFFFFFFFFF88);
        xact("lbu_17", 0, 3'b100, 64'h17, 64'h0, rd, er);
        chk("lbu_17_lit", rd, 64'h88);
        xact("lh_16", 0, 3'b001, 64'h16, 64'h0, rd, er);
        chk("lh_16_lit", rd, 64'hFFFFFFFFFFFF8877);
        xact("lw_14", 0, 3'b010, 64'h14, 64'h0, rd, er);
        chk("lw_14_lit", rd, 64'hFFFFFFFF88776655);
        xact("lwu_10", 0, 3'b110, 64'h10, 64'h0, rd, er);
        chk("lwu_10_lit", rd, 64'h44332211);
        xact("sb_13", 1, 3'b000, 64'h13, 64'hAA, rd, er);
        xact("ld_10b", 0, 3'b011, 64'h10, 64'h0, rd, er);
        chk("sb_lane3_lit", rd, 64'h88776655AA332211);

        // Error cases
        xact("lw_12", 0, 3'b010, 64'h12, 64'h0, rd, er);
        chk("lw_12_lit_err", 64'(er), 64'd1);
        xact("sh_11", 1, 3'b001, 64'h11, 64'hFFFF, rd, er);
        chk("sh_11_lit_err", 64'(er), 64'd1);
        xact("f3_111", 0, 3'b111, 64'h10, 64'h0, rd, er);
        chk("f3_111_lit_err", 64'(er), 64'd1);
        xact("sw_f3_110", 1, 3'b110, 64'h10, 64'hDEADBEEF, rd, er);
        chk("sw_f3_110_lit_err", 64'(er), 64'd1);
        xact("ld_oob", 0, 3'b011, BASE + 64'(8*DEPTH), 64'h0, rd, er);
        chk("ld_oob_lit_err", 64'(er), 64'd1);
        chk("ld_oob_lit_rd", rd, 64'd0);
        xact("ld_10c", 0, 3'b011, 64'h10, 64'h0, rd, er);
        chk("unchanged_lit", rd, 64'h88776655AA332211);

        // Last doubleword is legal; wrap-around address is not
        xact("sd_last", 1, 3'b011, BASE + 64'(8*(DEPTH-1)), 64'h0123456789ABCDEF, rd, er);
        xact("ld_last", 0, 3'b011, BASE + 64'(8*(DEPTH-1)), 64'h0, rd, er);
        chk("ld_last_lit", rd, 64'h0123456789ABCDEF);
        xact("ld_wrap", 0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 64'h0, rd, er);

        // Response backpressure with a second request waiting
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b011; req_addr_i = 64'h10;
        @(posedge clk);
        #1 req_funct3_i = 3'b010; req_addr_i = 64'h14;
        @(negedge clk);
        chk("bp_busy_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        chk("bp_valid", 64'(resp_valid_o), 64'd1);
        rd0 = resp_rdata_o;
        chk("bp_rdata", rd0, 64'h88776655AA332211);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(resp_valid_o), 64'd1);
            chk("bp_hold_rdata", resp_rdata_o, rd0);
            chk("bp_hold_err", 64'(resp_err_o), 64'd0);
            chk("bp_hold_ready", 64'(req_ready_o), 64'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        collect(rd, er);
        $display("xact bp_second lw addr=14 -> rdata=%h err=%0d", rd, er);
        chk("bp_second_rdata", rd, 64'hFFFFFFFF88776655);

        // Reset during BUSY suppresses the store and its response
        xact("sd_20_5", 1, 3'b011, 64'h20, 64'h5, rd, er);
        issue(1, 3'b011, 64'h20, 64'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy_no_valid", 64'(resp_valid_o), 64'd0);
        end
        $display("xact sd_20_1 aborted by reset");
        xact("ld_20", 0, 3'b011, 64'h20, 64'h0, rd, er);
        chk("ld_20_lit", rd, 64'h5);

        // Randomized traffic over a seeded region
        for (int i = 0; i < 32; i++) begin
            d = {$urandom, $urandom};
            xact("fill", 1, 3'b011, 64'(8*i), d, rd, er);
        end
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = BASE + 64'(8*DEPTH) + 64'($urandom_range(0, 64));
            else a = 64'($urandom_range(0, 255));
            d = {$urandom, $urandom};
            xact("rand", we, f3, a, d, rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
